// File: rtl/gobang_pkg.sv
// Shared board geometry, direction/player encodings and FSM states for the
// gobang five-in-a-row logic.
package gobang_pkg;
    localparam int BOARD_W = 10;
    localparam int BOARD_H = 10;
    localparam int WIN_LEN = 5;
    localparam int POS_W   = 7;
    localparam int CELLS   = BOARD_W * BOARD_H;
    localparam int COORD_W = 4;
    localparam int CNT_W   = $clog2(WIN_LEN + 1);

    localparam logic [1:0] DIR_H = 2'd0;
    localparam logic [1:0] DIR_V = 2'd1;
    localparam logic [1:0] DIR_D = 2'd2;
    localparam logic [1:0] DIR_A = 2'd3;

    localparam logic RED   = 1'b0;
    localparam logic GREEN = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        STEP,
        FINISH
    } state_t;

    // Off-board indices read as empty so callers need no separate range test.
    function automatic logic cell_bit(input logic [CELLS-1:0] board,
                                      input logic [POS_W-1:0] idx);
        return (idx < POS_W'(CELLS)) ? board[idx] : 1'b0;
    endfunction
endpackage

// File: rtl/gobang_step_addr.sv
// Combinational one-cell step along a board direction with per-axis bounds
// checking (no wrap between rows). Shared with the game-control cursor.
module gobang_step_addr
    import gobang_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         dir,
    input  logic               sense,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               in_bounds
);
    logic x_move, y_move, x_neg, y_neg, x_ok, y_ok;

    always_comb begin
        x_move = (dir != DIR_V);
        y_move = (dir != DIR_H);
        // sense=1 is the forward direction; anti-diagonal runs +x,-y forward
        x_neg  = !sense;
        y_neg  = (dir == DIR_A) ? sense : !sense;

        x_ok   = !x_move || (x_neg ? (x != '0) : (x < COORD_W'(BOARD_W - 1)));
        y_ok   = !y_move || (y_neg ? (y != '0) : (y < COORD_W'(BOARD_H - 1)));

        next_x = !x_move ? x : (x_neg ? x - COORD_W'(1) : x + COORD_W'(1));
        next_y = !y_move ? y : (y_neg ? y - COORD_W'(1) : y + COORD_W'(1));
        in_bounds = x_ok && y_ok;
    end
endmodule

// File: rtl/gobang_win_checker.sv
// Sequential five-in-a-row detector: walks the four lines through the placed
// stone one probe per cycle. Optional win_mask output under GOBANG_WIN_MASK_EN.
module gobang_win_checker
    import gobang_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             player,
    input  logic [POS_W-1:0] move_pos,
    input  logic [CELLS-1:0] Player_Red,
    input  logic [CELLS-1:0] Player_Green,
    output logic             busy,
    output logic             done,
    output logic             win,
    output logic             winner,
`ifdef GOBANG_WIN_MASK_EN
    output logic [CELLS-1:0] win_mask,
`endif
    output logic [1:0]       win_dir
);
    state_t             state_reg, state_next;
    logic               player_reg, player_next;
    logic [POS_W-1:0]   pos_reg, pos_next;
    logic [CELLS-1:0]   board_reg, board_next;
    logic [1:0]         dir_reg, dir_next;
    logic               sense_reg, sense_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [COORD_W-1:0] cur_x_reg, cur_x_next, cur_y_reg, cur_y_next;
    logic [COORD_W-1:0] org_x_reg, org_x_next, org_y_reg, org_y_next;
    logic               win_reg, win_next, winner_reg, winner_next;
    logic [1:0]         win_dir_reg, win_dir_next;
`ifdef GOBANG_WIN_MASK_EN
    logic [CELLS-1:0]   mask_reg, mask_next;
`endif

    logic [COORD_W-1:0] step_x, step_y;
    logic               step_ok, hit;
    logic [POS_W-1:0]   step_idx;

    gobang_step_addr u_step (
        .x         (cur_x_reg),
        .y         (cur_y_reg),
        .dir       (dir_reg),
        .sense     (sense_reg),
        .next_x    (step_x),
        .next_y    (step_y),
        .in_bounds (step_ok)
    );

    assign step_idx = POS_W'(step_y) * POS_W'(BOARD_W) + POS_W'(step_x);
    assign hit      = step_ok && cell_bit(board_reg, step_idx);

    always_comb begin
        state_next   = state_reg;
        player_next  = player_reg;
        pos_next     = pos_reg;
        board_next   = board_reg;
        dir_next     = dir_reg;
        sense_next   = sense_reg;
        count_next   = count_reg;
        cur_x_next   = cur_x_reg;
        cur_y_next   = cur_y_reg;
        org_x_next   = org_x_reg;
        org_y_next   = org_y_reg;
        win_next     = win_reg;
        winner_next  = winner_reg;
        win_dir_next = win_dir_reg;
`ifdef GOBANG_WIN_MASK_EN
        mask_next    = mask_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    player_next  = player;
                    pos_next     = move_pos;
                    board_next   = (player == GREEN) ? Player_Green : Player_Red;
                    win_next     = 1'b0;
                    winner_next  = 1'b0;
                    win_dir_next = DIR_H;
`ifdef GOBANG_WIN_MASK_EN
                    mask_next    = '0;
`endif
                    state_next   = CHECK;
                end
            end
            CHECK: begin
                if (!cell_bit(board_reg, pos_reg)) begin
                    state_next = FINISH;
                end else begin
                    org_x_next = COORD_W'(pos_reg % POS_W'(BOARD_W));
                    org_y_next = COORD_W'(pos_reg / POS_W'(BOARD_W));
                    cur_x_next = COORD_W'(pos_reg % POS_W'(BOARD_W));
                    cur_y_next = COORD_W'(pos_reg / POS_W'(BOARD_W));
                    dir_next   = DIR_H;
                    sense_next = 1'b1;
                    count_next = CNT_W'(1);
`ifdef GOBANG_WIN_MASK_EN
                    mask_next  = CELLS'(1) << pos_reg;
`endif
                    state_next = STEP;
                end
            end
            STEP: begin
                if (hit) begin
                    count_next = count_reg + CNT_W'(1);
                    cur_x_next = step_x;
                    cur_y_next = step_y;
`ifdef GOBANG_WIN_MASK_EN
                    mask_next  = mask_reg | (CELLS'(1) << step_idx);
`endif
                    if (count_reg + CNT_W'(1) == CNT_W'(WIN_LEN)) begin
                        win_next     = 1'b1;
                        winner_next  = player_reg;
                        win_dir_next = dir_reg;
                        state_next   = FINISH;
                    end
                end else if (sense_reg) begin
                    // forward run ended: restart from the origin going backward
                    sense_next = 1'b0;
                    cur_x_next = org_x_reg;
                    cur_y_next = org_y_reg;
                end else begin
                    cur_x_next = org_x_reg;
                    cur_y_next = org_y_reg;
                    sense_next = 1'b1;
                    count_next = CNT_W'(1);
                    dir_next   = dir_reg + 2'd1;
`ifdef GOBANG_WIN_MASK_EN
                    mask_next  = (dir_reg == DIR_A) ? '0 : (CELLS'(1) << pos_reg);
`endif
                    if (dir_reg == DIR_A) state_next = FINISH;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            player_reg  <= 1'b0;
            pos_reg     <= '0;
            board_reg   <= '0;
            dir_reg     <= DIR_H;
            sense_reg   <= 1'b0;
            count_reg   <= '0;
            cur_x_reg   <= '0;
            cur_y_reg   <= '0;
            org_x_reg   <= '0;
            org_y_reg   <= '0;
            win_reg     <= 1'b0;
            winner_reg  <= 1'b0;
            win_dir_reg <= DIR_H;
`ifdef GOBANG_WIN_MASK_EN
            mask_reg    <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            player_reg  <= player_next;
            pos_reg     <= pos_next;
            board_reg   <= board_next;
            dir_reg     <= dir_next;
            sense_reg   <= sense_next;
            count_reg   <= count_next;
            cur_x_reg   <= cur_x_next;
            cur_y_reg   <= cur_y_next;
            org_x_reg   <= org_x_next;
            org_y_reg   <= org_y_next;
            win_reg     <= win_next;
            winner_reg  <= winner_next;
            win_dir_reg <= win_dir_next;
`ifdef GOBANG_WIN_MASK_EN
            mask_reg    <= mask_next;
`endif
        end
    end

    assign busy    = (state_reg == CHECK) || (state_reg == STEP);
    assign done    = (state_reg == FINISH);
    assign win     = win_reg;
    assign winner  = winner_reg;
    assign win_dir = win_dir_reg;
`ifdef GOBANG_WIN_MASK_EN
    assign win_mask = mask_reg;
`endif
endmodule

// File: tb/tb_gobang_win_checker.sv
// Self-checking bench for gobang_win_checker: directed plan cases, reset and
// start-while-busy cases, then randomized boards against a line-run model.
module tb_gobang_win_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        player = 1'b0;
    logic [6:0]  move_pos = '0;
    logic [99:0] red = '0;
    logic [99:0] green = '0;
    logic        busy, done, win, winner;
    logic [1:0]  win_dir;
`ifdef GOBANG_WIN_MASK_EN
    logic [99:0] win_mask;
`endif

    int n_checks = 0;
    int n_fail = 0;

    gobang_win_checker dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .player       (player),
        .move_pos     (move_pos),
        .Player_Red   (red),
        .Player_Green (green),
        .busy         (busy),
        .done         (done),
        .win          (win),
        .winner       (winner),
`ifdef GOBANG_WIN_MASK_EN
        .win_mask     (win_mask),
`endif
        .win_dir      (win_dir)
    );

    always #5 clk = ~clk;

    function automatic void dvec(input int d, output int dx, output int dy);
        case (d)
            0: begin dx = 1; dy = 0;  end
            1: begin dx = 0; dy = 1;  end
            2: begin dx = 1; dy = 1;  end
            default: begin dx = 1; dy = -1; end
        endcase
    endfunction

    function automatic int run_len(input logic [99:0] b, input int x, input int y,
                                   input int dx, input int dy);
        int k = 0;
        int cx = x + dx;
        int cy = y + dy;
        while (cx >= 0 && cx < 10 && cy >= 0 && cy < 10 && b[cy*10+cx]) begin
            k++; cx += dx; cy += dy;
        end
        return k;
    endfunction

    // Reference: first direction whose full run through the origin reaches 5;
    // latency counts one cycle per probe, plus the check and finish cycles.
    function automatic void model(input logic [99:0] b, input int pos, output bit w,
                                  output int wd, output int lat, output logic [99:0] m);
        int x, y, dx, dy, rp, rm, tp, tm, probes;
        w = 0; wd = 0; lat = 2; m = '0;
        if (pos >= 100 || !b[pos]) return;
        x = pos % 10; y = pos / 10; probes = 0;
        for (int d = 0; d < 4; d++) begin
            dvec(d, dx, dy);
            rp = run_len(b, x, y, dx, dy);
            rm = run_len(b, x, y, -dx, -dy);
            if (rp + rm + 1 >= 5) begin
                tp = (rp >= 4) ? 4 : rp;
                tm = 4 - tp;
                probes += (rp >= 4) ? 4 : rp + 1 + tm;
                w = 1; wd = d; lat = probes + 2;
                m[pos] = 1'b1;
                for (int k = 1; k <= tp; k++) m[(y + k*dy)*10 + x + k*dx] = 1'b1;
                for (int k = 1; k <= tm; k++) m[(y - k*dy)*10 + x - k*dx] = 1'b1;
                return;
            end
            probes += rp + rm + 2;
        end
        lat = probes + 2;
    endfunction

    // Drives one start pulse, scrambles the board afterwards, waits for done.
    task automatic run_scan(input logic pl, input int pos, input logic [99:0] r,
                            input logic [99:0] g, output int lat, output logic busy1);
        @(negedge clk);
        player = pl; move_pos = pos[6:0]; red = r; green = g; start = 1'b1;
        lat = 0; busy1 = 1'b0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0; busy1 = busy; red = ~r; green = ~g;
            end
            if (done) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, win, winner, win_dir} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000", {busy, done, win, winner, win_dir});
        end
`ifdef GOBANG_WIN_MASK_EN
        n_checks++;
        if (win_mask !== '0) begin
            n_fail++; $display("FAIL reset_mask: got %h expected 0", win_mask);
        end
`endif
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_directed();
        logic [99:0] r, g, b, em;
        logic pl, busy1;
        int pos, lat, ed, el;
        bit ew;
        for (int c = 0; c < 6; c++) begin
            r = '0; g = '0; pl = 1'b0; pos = 0;
            case (c)
                0: begin for (int i = 30; i <= 34; i++) r[i] = 1'b1; g[35] = 1'b1; pos = 32; end
                1: begin for (int i = 5; i <= 9; i++) g[i*10+9] = 1'b1; pl = 1'b1; pos = 99; end
                2: begin r[8] = 1'b1; r[9] = 1'b1; r[10] = 1'b1; r[11] = 1'b1; r[12] = 1'b1; pos = 9; end
                3: begin g[40] = 1'b1; g[31] = 1'b1; g[22] = 1'b1; g[13] = 1'b1; g[4] = 1'b1; pl = 1'b1; pos = 22; end
                4: begin r[44] = 1'b1; r[46] = 1'b1; pos = 45; end
                default: begin r = '1; pos = 100; end
            endcase
            b = pl ? g : r;
            model(b, pos, ew, ed, el, em);
            run_scan(pl, pos, r, g, lat, busy1);
            $display("directed case %0d pos=%0d: lat=%0d win=%0d winner=%0d dir=%0d", c, pos, lat, win, winner, win_dir);
            n_checks += 5;
            if (lat != el) begin n_fail++; $display("FAIL dir_latency case %0d: got %0d expected %0d", c, lat, el); end
            if (busy1 !== 1'b1) begin n_fail++; $display("FAIL dir_busy case %0d: got %b expected 1", c, busy1); end
            if (win !== ew) begin n_fail++; $display("FAIL dir_win case %0d: got %b expected %0d", c, win, ew); end
            if (winner !== (ew ? pl : 1'b0)) begin n_fail++; $display("FAIL dir_winner case %0d: got %b expected %b", c, winner, ew ? pl : 1'b0); end
            if (win_dir !== 2'(ed)) begin n_fail++; $display("FAIL dir_windir case %0d: got %0d expected %0d", c, win_dir, ed); end
`ifdef GOBANG_WIN_MASK_EN
            if (ew) begin
                n_checks++;
                if (win_mask !== em) begin n_fail++; $display("FAIL dir_mask case %0d: got %h expected %h", c, win_mask, em); end
            end
`endif
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL dir_done_pulse case %0d: got done=%b busy=%b expected 0 0", c, done, busy);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [99:0] g, r;
        logic busy1;
        int lat, ndone;
        g = '0; for (int i = 5; i <= 9; i++) g[i*10+9] = 1'b1;
        run_scan(1'b1, 99, '0, g, lat, busy1);
        @(negedge clk);
        rst = 1'b1; #1;
        $display("reset after win: win=%b winner=%b dir=%0d", win, winner, win_dir);
        n_checks++;
        if ({win, winner, win_dir} !== 4'b0) begin
            n_fail++; $display("FAIL reset_after_win: got %b expected 0000", {win, winner, win_dir});
        end
        @(negedge clk); rst = 1'b0;
        r = '0; r[55] = 1'b1;
        @(negedge clk);
        player = 1'b0; move_pos = 7'd55; red = r; start = 1'b1;
        repeat (4) begin @(negedge clk); start = 1'b0; end
        rst = 1'b1; #1;
        $display("reset mid-scan: busy=%b done=%b", busy, done);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_busy: got busy=%b done=%b expected 0 0", busy, done);
        end
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        repeat (15) begin @(negedge clk); if (done) ndone++; end
        n_checks++;
        if (ndone != 0) begin n_fail++; $display("FAIL reset_mid_nodone: got %0d done pulses expected 0", ndone); end
    endtask

    task automatic test_back_to_back();
        logic [99:0] r;
        int ndone, first_lat;
        r = '0; r[55] = 1'b1; for (int i = 30; i <= 34; i++) r[i] = 1'b1;
        @(negedge clk);
        player = 1'b0; move_pos = 7'd55; red = r; start = 1'b1;
        ndone = 0; first_lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3) begin start = 1'b1; move_pos = 7'd32; end
            if (done) begin
                ndone++;
                if (first_lat == 0) first_lat = k;
                start = 1'b1; move_pos = 7'd32;
            end
        end
        $display("back-to-back: dones=%0d first_lat=%0d win=%b", ndone, first_lat, win);
        n_checks += 3;
        if (ndone != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 1", ndone); end
        if (first_lat != 10) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 10", first_lat); end
        if (win !== 1'b0) begin n_fail++; $display("FAIL b2b_win: got %b expected 0", win); end
    endtask

    task automatic test_random();
        logic [99:0] r, g, em;
        logic pl, busy1;
        int pos, lat, ed, el, d, s, dx, dy, cx, cy;
        bit ew;
        for (int it = 0; it < 60; it++) begin
            r = '0; g = '0;
            for (int i = 0; i < 100; i++) begin
                r[i] = ($urandom_range(0, 99) < 30);
                g[i] = ($urandom_range(0, 99) < 30);
            end
            pl = 1'($urandom_range(0, 1));
            pos = $urandom_range(0, 103);
            if (pos < 100 && $urandom_range(0, 1) == 1) begin
                d = $urandom_range(0, 3); s = $urandom_range(0, 4);
                dvec(d, dx, dy);
                for (int k = -s; k <= 4 - s; k++) begin
                    cx = pos % 10 + k*dx; cy = pos / 10 + k*dy;
                    if (cx >= 0 && cx < 10 && cy >= 0 && cy < 10) begin
                        if (pl) g[cy*10+cx] = 1'b1; else r[cy*10+cx] = 1'b1;
                    end
                end
            end
            model(pl ? g : r, pos, ew, ed, el, em);
            run_scan(pl, pos, r, g, lat, busy1);
            $display("random %0d pos=%0d pl=%0d: lat=%0d win=%0d dir=%0d", it, pos, pl, lat, win, win_dir);
            n_checks += 4;
            if (lat != el) begin n_fail++; $display("FAIL rnd_latency it %0d: got %0d expected %0d", it, lat, el); end
            if (win !== ew) begin n_fail++; $display("FAIL rnd_win it %0d: got %b expected %0d", it, win, ew); end
            if (winner !== (ew ? pl : 1'b0)) begin n_fail++; $display("FAIL rnd_winner it %0d: got %b expected %b", it, winner, ew ? pl : 1'b0); end
            if (win_dir !== 2'(ed)) begin n_fail++; $display("FAIL rnd_windir it %0d: got %0d expected %0d", it, win_dir, ed); end
`ifdef GOBANG_WIN_MASK_EN
            if (ew) begin
                n_checks++;
                if (win_mask !== em) begin n_fail++; $display("FAIL rnd_mask it %0d: got %h expected %h", it, win_mask, em); end
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
